// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline buffer with valid/ready handshake, flush and optional 2-entry skid.
// Holding M on out_data and counting entries in state_q keeps out_data glitch-free and makes level trivial.
module pipe_stage_buffer #(
    parameter int                DATA_W    = 32,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              in_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign level     = state_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              rdy_q;

            // in_ready comes straight from a flop so no input reaches it combinationally
            assign in_ready = rdy_q;
            assign in_xfer  = in_valid & rdy_q;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                    skid_d  = FLUSH_VAL;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                state_d = ST_ONE;
                                main_d  = in_data;
                            end
                        end
                        ST_ONE: begin
                            if (in_xfer && out_ready) begin
                                main_d = in_data;
                            end else if (in_xfer) begin
                                state_d = ST_TWO;
                                skid_d  = in_data;
                            end else if (out_ready) begin
                                state_d = ST_EMPTY;
                                main_d  = FLUSH_VAL;
                            end
                        end
                        ST_TWO: begin
                            if (out_ready) begin
                                state_d = ST_ONE;
                                main_d  = skid_q;
                                skid_d  = FLUSH_VAL;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                            main_d  = FLUSH_VAL;
                            skid_d  = FLUSH_VAL;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_EMPTY;
                    main_q  <= FLUSH_VAL;
                    skid_q  <= FLUSH_VAL;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    rdy_q   <= (state_d != ST_TWO);
                end
            end
        end else begin : g_single
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
            assign in_xfer  = in_valid & in_ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                end else if (in_xfer) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end else if (state_q != ST_EMPTY && out_ready) begin
                    state_d = ST_EMPTY;
                    main_d  = FLUSH_VAL;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_EMPTY;
                    main_q  <= FLUSH_VAL;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised inter-stage pipeline buffer. It is the generalised successor to the fixed 16-bit PC/instruction stage register. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake, and adds flush with bubble injection. An optional 2-entry skid buffer lets upstream ready be fully registered, which breaks the combinational ready path between stages. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 32, payload width in bits (e.g. {pc, instr} = 32 for IF/ID).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single-entry register with combinational in_ready.
FLUSH_VAL, 0, value driven on out_data when the stage is empty or flushed (NOP encoding).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream accepts the payload this cycle
out_data  output  DATA_W  payload to the downstream stage
flush  input  1  synchronous kill of all held and incoming payloads
level  output  2  occupancy: 0, 1 or 2 (2 only when SKID=1)

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, out_data=FLUSH_VAL, level=0.
  - in_ready=1 while rst=0 for SKID=1; in_ready=1 for SKID=0, since the stage is empty.
  - Skid entry cleared to FLUSH_VAL.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
  - in_data is ignored when in_valid=0.
- Latency: 1 cycle. A payload accepted at edge N appears on out_data/out_valid after edge N.
- SKID=1 state machine (main register M, skid register S):
  - EMPTY (level 0):
    - Input transfer -> ONE, M<=in_data.
  - ONE (level 1):
    - Input transfer and out_ready -> ONE, M<=in_data (simultaneous pass-through).
    - Input transfer and !out_ready -> TWO, S<=in_data.
    - No input transfer and out_ready -> EMPTY, M<=FLUSH_VAL.
    - Otherwise hold.
  - TWO (level 2):
    - out_ready -> ONE, M<=S, S<=FLUSH_VAL.
    - Otherwise hold. No input transfer is possible because in_ready=0.
  - in_ready is a flop and equals (next state != TWO). It depends on no input combinationally.
  - out_valid = (state != EMPTY); out_data = M.
- SKID=0:
  - Single register M.
  - in_ready = !out_valid | out_ready (combinational).
  - Input transfer loads M and sets out_valid.
  - Output transfer without an input transfer clears out_valid and sets M<=FLUSH_VAL.
  - level is 0 or 1.
- Flush (priority over all handshakes):
  - Next edge: state EMPTY, out_valid=0, M and S <= FLUSH_VAL, level=0.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still completes downstream; the stage simply empties.
  - in_ready after a flush is 1.
- Hold: while out_valid=1 and out_ready=0, out_data and out_valid stay stable with no glitches. Back-pressure stalls the stage.
- Invariants:
  - Payload order is preserved.
  - No payload is duplicated or lost except by flush.
  - level always equals the count of valid entries.
- A mid-operation rst=0 clears everything immediately, regardless of clock.

Test Plan:
- Reset then stream: rst low 2 cycles, then in_valid=1 with in_data=0x0000_0010, 0x0000_0012, 0x0000_0014 and out_ready=1. Required: out_data shows 0x10, 0x12, 0x14 on consecutive cycles starting 1 cycle after each accept; level=1 throughout; in_ready stays 1.
- Back-pressure (SKID=1): load 0xA, drop out_ready, offer 0xB then 0xC. Required: 0xB is accepted, level=2, in_ready=0 the next cycle, 0xC is held upstream. Raising out_ready then yields 0xA, 0xB, 0xC in order with no loss.
- Flush with level=2: assert flush for 1 cycle while in_valid=1 with in_data=0xD. Required: next cycle out_valid=0, out_data=FLUSH_VAL, level=0, in_ready=1, and 0xD never appears.
- SKID=0 instance: out_ready=0 with a valid entry forces in_ready=0 in the same cycle. With out_ready=1 and in_valid=1, the stage swaps to the new payload each cycle; level never exceeds 1.
- Async reset mid-stream: rst=0 between clock edges while level=2. Required: out_valid=0 and level=0 immediately, without a clock edge; after release the first accepted payload is output normally.
- Random valid/ready (10k cycles, both SKID values): a scoreboard confirms in-order, lossless delivery and that level matches the number of outstanding payloads.
